// File: rtl/image_stream_fifo_pkg.sv
// Shared constants and helpers for the image stream FIFO and its storage.
package fifo_pkg;

  localparam int DEF_RAM_WIDTH     = 8;
  localparam int DEF_RAM_ADDR_BITS = 10;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy spans 0..DEPTH inclusive, so it needs one bit more than an address.
  function automatic int count_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/image_stream_fifo_ram_sdp.sv
// Simple-dual-port RAM with registered read; written to infer block RAM.
module ram_sdp
  import fifo_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [RAM_ADDR_BITS-1:0] i_waddr,
  input  logic [RAM_WIDTH-1:0]     i_din,
  input  logic                     i_re,
  input  logic [RAM_ADDR_BITS-1:0] i_raddr,
  output logic [RAM_WIDTH-1:0]     o_dout
);

  logic [RAM_WIDTH-1:0] r_mem [0:(2**RAM_ADDR_BITS)-1];

  // dout holds its value while i_re is low; the FIFO relies on that as a skid slot.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_din;
    if (i_re) o_dout <= r_mem[i_raddr];
  end

endmodule

// File: rtl/image_stream_fifo.sv
// Show-ahead synchronous FIFO for pixel streams: RAM, one read stage and an
// output register, all counted in occupancy.
module image_stream_fifo
  import fifo_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter int AF_THRESH     = 2**RAM_ADDR_BITS - 4
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      clear,
  input  logic                                      wr_valid,
  output logic                                      wr_ready,
  input  logic [RAM_WIDTH-1:0]                      wr_data,
  output logic                                      rd_valid,
  input  logic                                      rd_ready,
  output logic [RAM_WIDTH-1:0]                      rd_data,
  output logic [count_width(RAM_ADDR_BITS)-1:0]     count,
  output logic                                      almost_full
);

  localparam int CW    = count_width(RAM_ADDR_BITS);
  localparam int DEPTH = 2**RAM_ADDR_BITS;
  localparam logic [CW-1:0]            DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]            AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0]            ONE_C   = CW'(1);
  localparam logic [RAM_ADDR_BITS-1:0] ONE_A   = RAM_ADDR_BITS'(1);

  logic [RAM_ADDR_BITS-1:0] r_wr_ptr;
  logic [RAM_ADDR_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic [CW-1:0]            r_ram_cnt;
  logic                     r_wr_ready;
  logic                     r_af;
  logic                     r_s1_vld;
  logic                     r_out_vld;
  logic [RAM_WIDTH-1:0]     r_out_data;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_s1_adv;
  logic                     w_re;
  logic [CW-1:0]            w_count_nxt;
  logic [CW-1:0]            w_ram_cnt_nxt;
  logic [RAM_WIDTH-1:0]     w_ram_dout;

  assign w_push   = wr_valid & r_wr_ready & ~clear;
  assign w_pop    = r_out_vld & rd_ready & ~clear;
  // The read stage moves forward whenever the output register is free or being drained.
  assign w_s1_adv = r_s1_vld & (~r_out_vld | w_pop);
  assign w_re     = ~clear & (r_ram_cnt != '0) & (~r_s1_vld | w_s1_adv);

  always_comb begin
    w_count_nxt = r_count;
    if (clear)                 w_count_nxt = '0;
    else if (w_push & ~w_pop)  w_count_nxt = r_count + ONE_C;
    else if (w_pop & ~w_push)  w_count_nxt = r_count - ONE_C;
  end

  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    if (clear)                w_ram_cnt_nxt = '0;
    else if (w_push & ~w_re)  w_ram_cnt_nxt = r_ram_cnt + ONE_C;
    else if (w_re & ~w_push)  w_ram_cnt_nxt = r_ram_cnt - ONE_C;
  end

  ram_sdp #(
    .RAM_WIDTH     (RAM_WIDTH),
    .RAM_ADDR_BITS (RAM_ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_din   (wr_data),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_dout  (w_ram_dout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ram_cnt  <= '0;
      r_wr_ready <= 1'b0;
      r_af       <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_ram_cnt  <= w_ram_cnt_nxt;
      // Flags come from next-state count so they line up with count on the same edge.
      r_wr_ready <= (w_count_nxt < DEPTH_C);
      r_af       <= (w_count_nxt >= AF_C);
      if (clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_s1_vld   <= 1'b0;
        r_out_vld  <= 1'b0;
        r_out_data <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ONE_A;
        if (w_re)   r_rd_ptr <= r_rd_ptr + ONE_A;
        r_s1_vld <= w_re | (r_s1_vld & ~w_s1_adv);
        if (w_s1_adv) begin
          r_out_vld  <= 1'b1;
          r_out_data <= w_ram_dout;
        end else if (w_pop) begin
          r_out_vld  <= 1'b0;
        end
      end
    end
  end

  assign wr_ready    = r_wr_ready;
  assign rd_valid    = r_out_vld;
  assign rd_data     = r_out_data;
  assign count       = r_count;
  assign almost_full = r_af;

endmodule

// File: tb/tb_image_stream_fifo.sv
// Directed bench for image_stream_fifo at DEPTH=16, AF_THRESH=12.
module tb_image_stream_fifo;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       almost_full;

  int n_vec;
  int n_err;

  image_stream_fifo #(
    .RAM_WIDTH     (8),
    .RAM_ADDR_BITS (4),
    .AF_THRESH     (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    repeat (3) tick();
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", count); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got=%b want=0", almost_full); end
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready got=%b want=0", wr_ready); end
    n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
    reset_n = 1'b1;
    #1;
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL release_wr_ready_early got=%b want=0", wr_ready); end
    tick();
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL release_wr_ready got=%b want=1", wr_ready); end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL release_count got=%0d want=0", count); end
  endtask

  task automatic test_latency();
    wr_valid = 1'b1; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL lat_n0_valid got=%b want=0", rd_valid); end
    tick();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1_valid got=%b want=0", rd_valid); end
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      n_err++; $display("FAIL lat_n2 got valid=%b data=%h want valid=1 data=a5", rd_valid, rd_data);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 5'd1) begin
        n_err++; $display("FAIL lat_hold%0d got valid=%b data=%h count=%0d want 1/a5/1", i, rd_valid, rd_data, count);
      end
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_pop got count=%0d valid=%b want 0/0", count, rd_valid);
    end
  endtask

  task automatic test_fill();
    int exp;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d got=%b want=1", i, wr_ready); end
      wr_valid = 1'b1; wr_data = 8'(i);
      tick();
      n_vec++; if (count !== 5'(i + 1) || almost_full !== ((i + 1) >= 12)) begin
        n_err++; $display("FAIL fill%0d got count=%0d af=%b want count=%0d af=%b", i, count, almost_full, i + 1, (i + 1) >= 12);
      end
    end
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_wr_ready got=%b want=0", wr_ready); end
    wr_data = 8'hEE;
    tick();
    n_vec++; if (count !== 5'd16 || wr_ready !== 1'b0) begin
      n_err++; $display("FAIL full_17th got count=%0d ready=%b want 16/0", count, wr_ready);
    end
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      n_err++; $display("FAIL full_head got valid=%b data=%h want 1/00", rd_valid, rd_data);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0; wr_valid = 1'b0;
    n_vec++; if (count !== 5'd15 || wr_ready !== 1'b1 || rd_data !== 8'h01) begin
      n_err++; $display("FAIL full_pop got count=%0d ready=%b data=%h want 15/1/01", count, wr_ready, rd_data);
    end
    rd_ready = 1'b1;
    exp = 1;
    cyc = 0;
    while (exp < 16 && cyc < 100) begin
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'(exp)) begin
        n_err++; $display("FAIL drain%0d got valid=%b data=%h want 1/%h", exp, rd_valid, rd_data, 8'(exp));
      end
      exp++;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_end got count=%0d valid=%b want 0/0", count, rd_valid);
    end
  endtask

  task automatic test_stream();
    int sent;
    int rcv;
    int cyc;
    sent = 0; rcv = 0; cyc = 0;
    rd_ready = 1'b1;
    while (rcv < 100 && cyc < 300) begin
      wr_valid = (sent < 100);
      wr_data  = 8'(sent);
      if (rd_valid) begin
        n_vec++; if (rd_data !== 8'(rcv)) begin
          n_err++; $display("FAIL stream_data%0d got=%h want=%h", rcv, rd_data, 8'(rcv));
        end
        rcv++;
      end else if (rcv > 0) begin
        n_vec++; n_err++; $display("FAIL stream_gap at word %0d got valid=0 want=1", rcv);
      end
      n_vec++; if (count > 5'd3) begin n_err++; $display("FAIL stream_count got=%0d want<=3", count); end
      if (wr_valid && wr_ready) sent++;
      tick();
      cyc++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_vec++; if (rcv !== 100 || sent !== 100) begin
      n_err++; $display("FAIL stream_total got rcv=%0d sent=%0d want 100/100", rcv, sent);
    end
    n_vec++; if (cyc > 104) begin n_err++; $display("FAIL stream_rate got cycles=%0d want<=104", cyc); end
  endtask

  task automatic test_random();
    int sent;
    int rcv;
    int model;
    int cyc;
    logic wa, ra, stall;
    logic [7:0] held;
    sent = 0; rcv = 0; model = 0; cyc = 0;
    while (rcv < 1000 && cyc < 20000) begin
      wr_valid = (sent < 1000) && ($urandom_range(1, 0) == 1);
      wr_data  = 8'(sent);
      rd_ready = ($urandom_range(1, 0) == 1);
      wa = wr_valid & wr_ready;
      ra = rd_valid & rd_ready;
      stall = rd_valid & ~rd_ready;
      held = rd_data;
      if (ra) begin
        n_vec++; if (rd_data !== 8'(rcv)) begin
          n_err++; $display("FAIL rand_data%0d got=%h want=%h", rcv, rd_data, 8'(rcv));
        end
        rcv++;
      end
      if (wa) sent++;
      tick();
      cyc++;
      model = model + int'(wa) - int'(ra);
      n_vec++; if (count !== 5'(model)) begin
        n_err++; $display("FAIL rand_count cyc%0d got=%0d want=%0d", cyc, count, model);
      end
      n_vec++; if (wr_ready !== (model < 16)) begin
        n_err++; $display("FAIL rand_wr_ready cyc%0d got=%b want=%b", cyc, wr_ready, model < 16);
      end
      if (stall) begin
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== held) begin
          n_err++; $display("FAIL rand_stall cyc%0d got valid=%b data=%h want 1/%h", cyc, rd_valid, rd_data, held);
        end
      end
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_vec++; if (rcv !== 1000) begin n_err++; $display("FAIL rand_total got=%0d want=1000", rcv); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    n_vec++; if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== 8'h10) begin
      n_err++; $display("FAIL clr_setup got count=%0d valid=%b data=%h want 5/1/10", count, rd_valid, rd_data);
    end
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h99; rd_ready = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_err++; $display("FAIL clr_state got count=%0d valid=%b data=%h want 0/0/00", count, rd_valid, rd_data);
    end
    n_vec++; if (wr_ready !== 1'b1 || almost_full !== 1'b0) begin
      n_err++; $display("FAIL clr_flags got ready=%b af=%b want 1/0", wr_ready, almost_full);
    end
    wr_valid = 1'b1; wr_data = 8'h3C;
    tick();
    wr_valid = 1'b0;
    tick();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_lat1 got valid=%b want=0", rd_valid); end
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C || count !== 5'd1) begin
      n_err++; $display("FAIL clr_next got valid=%b data=%h count=%0d want 1/3c/1", rd_valid, rd_data, count);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL clr_drain got count=%0d valid=%b want 0/0", count, rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h50 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0 || rd_data !== 8'h00) begin
      n_err++; $display("FAIL midreset got count=%0d valid=%b ready=%b data=%h want 0/0/0/00", count, rd_valid, wr_ready, rd_data);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick(); tick();
    n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_after got count=%0d valid=%b ready=%b want 0/0/1", count, rd_valid, wr_ready);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_latency();
    test_fill();
    test_stream();
    test_random();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/image_stream_fifo.md
Name: image_stream_fifo

Overview:
- Parametrised synchronous FIFO for pixel/byte streams.
- Successor to the single-port inferred image RAM: separate write and read ports, valid/ready handshakes on both sides, occupancy tracking, flush.
- Sits between the image source (UART/loader) and the pixel consumer (display/processing), all in one clock domain.
- Storage is an inferred simple-dual-port RAM with synchronous read, so it maps to block RAM.

Parameters:
- RAM_WIDTH, 8: data word width in bits.
- RAM_ADDR_BITS, 10: log2 of storage depth; capacity DEPTH = 2**RAM_ADDR_BITS words.
- AF_THRESH, 2**RAM_ADDR_BITS-4: almost_full asserts when count >= AF_THRESH. Legal range is 1..DEPTH.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active high.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  FIFO can accept a word; registered.
- wr_data  in  RAM_WIDTH  write word.
- rd_valid  out  1  rd_data holds the oldest word; registered.
- rd_ready  in  1  consumer takes rd_data.
- rd_data  out  RAM_WIDTH  oldest word; registered.
- count  out  RAM_ADDR_BITS+1  words accepted and not yet popped (0..DEPTH).
- almost_full  out  1  count >= AF_THRESH; registered.

Behaviour:
- Interface rules (already decided): one clock, clk; asynchronous active-low reset, reset_n.
- Reset (reset_n=0, takes effect immediately):
  - count=0, rd_valid=0, rd_data=0, almost_full=0, wr_ready=0, all pointers 0.
  - wr_ready rises on the first clk edge after reset_n deasserts.
  - RAM contents are not reset.
- Push occurs on an edge with wr_valid & wr_ready. Pop occurs on an edge with rd_valid & rd_ready.
- Ready is not combinationally dependent on rd_ready:
  - When count==DEPTH, wr_ready=0 even if a pop happens in the same cycle.
  - wr_ready rises on the edge after the pop.
- count update per edge: +1 on push only; -1 on pop only; unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
- Show-ahead (first-word fall-through) read:
  - When the FIFO is empty, a word pushed at edge N gives rd_valid=1 with that word after edge N+2.
  - rd_data and rd_valid stay stable while rd_valid & !rd_ready; a word is never dropped or duplicated.
- Throughput: sustained 1 word/cycle in and out with wr_valid=rd_ready=1 continuously, once primed.
- Internal pipeline: RAM read stage plus output register, with prefetch/skid so the pipeline never stalls. Words in these stages count toward count. A RAM slot frees when its word moves into the pipeline.
- Pointers: wr_ptr and rd_ptr are RAM_ADDR_BITS wide and wrap modulo DEPTH with no special case.
- clear:
  - Synchronous; takes priority over push and pop in the same cycle.
  - On the next edge: pointers=0, count=0, rd_valid=0, pipeline emptied, rd_data=0.
  - A push or pop in the clear cycle is discarded.
- almost_full is recomputed from the next-state count, so it is exact on the same edge as count.
- Reset asserted mid-transfer: all words are lost and state returns to the reset values immediately.

Decomposition:
- Shared package (fifo_pkg):
  - default RAM_WIDTH and RAM_ADDR_BITS constants;
  - a clog2 function;
  - the count width expression RAM_ADDR_BITS+1.
- Sub-module ram_sdp:
  - inferred simple-dual-port RAM: write port (we, waddr, din) and registered read port (re, raddr, dout), same parameters;
  - no reset on the array.
- Top-level image_stream_fifo holds the pointers, count, prefetch/output pipeline and flags.

Test Plan:
- Reset then idle: reset_n low 3 cycles, then high → count=0, rd_valid=0, almost_full=0; wr_ready=1 one edge after release.
- Latency: empty FIFO, push 0xA5 at edge N, rd_ready=0 → rd_valid=1 with rd_data=0xA5 after edge N+2. It holds 10 cycles with count=1; pop → count=0, rd_valid=0.
- Fill and full: RAM_ADDR_BITS=4, push 0x00..0x0F with rd_ready=0 → count=16, wr_ready=0, almost_full=1 from count=12. A 17th wr_valid is not accepted. One pop → wr_ready=1 on the next edge.
- Streaming wrap: DEPTH=16, push 0..99 with wr_valid=rd_ready=1 continuously → output 0..99 in order, one per cycle after priming; count ≤ 3; no gaps after priming.
- Random backpressure: random wr_valid and rd_ready (50%), 1000 words → scoreboard matches in order; count equals pushes minus pops every cycle; rd_data stable while stalled.
- Clear priority: count=5 with push and pop asserted together with clear → next edge count=0, rd_valid=0. The next push 0x3C appears after 2 edges.
